// File: rtl/regfile_writeback_unit.sv
// regfile_writeback_unit
// Drives the single register-file write port from two sources: single-cycle
// ALU results (fixed priority) and in-order load responses, which are tagged
// with their destination at issue time and parked in a small data buffer.
// A 32-bit busy scoreboard marks registers with an outstanding load.
// Optional feature macro: WB_LOAD_BYPASS_EN -- when defined, a load response
// arriving while the data buffer is empty and the ALU is not writing goes
// straight to the write port instead of passing through the buffer.
module regfile_writeback_unit #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            ld_req_valid,
   input  logic [4:0]      ld_req_rd,
   output logic            ld_req_ready,
   input  logic            ld_rsp_valid,
   input  logic [XLEN-1:0] ld_rsp_data,
   output logic            ld_rsp_ready,
   output logic            wr_en,
   output logic [4:0]      wr_addr,
   output logic [XLEN-1:0] wr_data,
   output logic [31:0]     busy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] PTR_WRAP = {1'b1, {AW{1'b0}}};

   // Tag FIFO: destination registers of issued loads, in issue order.
   logic [4:0]      tag_mem [DEPTH];
   logic [AW:0]     tag_wr_ptr_reg, tag_rd_ptr_reg;
   // Data buffer: returned loads waiting for a free write-port slot.
   logic [4:0]      buf_rd_mem   [DEPTH];
   logic [XLEN-1:0] buf_data_mem [DEPTH];
   logic [AW:0]     buf_wr_ptr_reg, buf_rd_ptr_reg;

   logic [31:0]     busy_reg, busy_next;
   logic            wr_en_reg, wr_en_next;
   logic [4:0]      wr_addr_reg, wr_addr_next;
   logic [XLEN-1:0] wr_data_reg, wr_data_next;
   logic            wr_from_ld_reg, wr_from_ld_next;

   logic            tag_full, tag_empty, buf_full, buf_empty;
   logic            alu_wr, req_fire, rsp_fire, drain_pop, bypass, buf_push;
   logic            busy_clr, busy_set;
   logic [4:0]      tag_head, head_rd;
   logic [XLEN-1:0] head_data;

   // Extra pointer bit separates full (MSBs differ) from empty (all equal).
   assign tag_empty = (tag_wr_ptr_reg == tag_rd_ptr_reg);
   assign tag_full  = ((tag_wr_ptr_reg ^ tag_rd_ptr_reg) == PTR_WRAP);
   assign buf_empty = (buf_wr_ptr_reg == buf_rd_ptr_reg);
   assign buf_full  = ((buf_wr_ptr_reg ^ buf_rd_ptr_reg) == PTR_WRAP);

   assign tag_head  = tag_mem[tag_rd_ptr_reg[AW-1:0]];
   assign head_rd   = buf_rd_mem[buf_rd_ptr_reg[AW-1:0]];
   assign head_data = buf_data_mem[buf_rd_ptr_reg[AW-1:0]];

   // Readies are forced low while reset is asserted so every output reads 0.
   assign alu_ready    = rst_n & ~busy_reg[alu_rd];
   assign ld_req_ready = rst_n & ~tag_full & ~busy_reg[ld_req_rd];
   assign ld_rsp_ready = rst_n & ~tag_empty & ~buf_full;

   assign alu_wr    = alu_valid & alu_ready & (alu_rd != 5'd0);
   assign req_fire  = ld_req_valid & ld_req_ready;
   assign rsp_fire  = ld_rsp_valid & ld_rsp_ready;
   // The buffer head drains whenever the ALU does not claim the port.
   assign drain_pop = ~buf_empty & ~alu_wr;

`ifdef WB_LOAD_BYPASS_EN
   assign bypass = rsp_fire & buf_empty & ~alu_wr;
`else
   assign bypass = 1'b0;
`endif
   assign buf_push = rsp_fire & ~bypass;

   // Select the next write-port contents: ALU first, then buffer head, then bypass.
   always_comb begin
      wr_en_next      = 1'b0;
      wr_addr_next    = 5'd0;
      wr_data_next    = '0;
      wr_from_ld_next = 1'b0;
      if (alu_wr) begin
         wr_en_next   = 1'b1;
         wr_addr_next = alu_rd;
         wr_data_next = alu_data;
      end else if (drain_pop) begin
         if (head_rd != 5'd0) begin
            wr_en_next      = 1'b1;
            wr_addr_next    = head_rd;
            wr_data_next    = head_data;
            wr_from_ld_next = 1'b1;
         end
      end else if (bypass && (tag_head != 5'd0)) begin
         wr_en_next      = 1'b1;
         wr_addr_next    = tag_head;
         wr_data_next    = ld_rsp_data;
         wr_from_ld_next = 1'b1;
      end
   end

   // A load write on the port clears its busy bit at the end of that cycle.
   assign busy_clr = wr_en_reg & wr_from_ld_reg;
   assign busy_set = req_fire;

   genvar gi;
   generate
      for (gi = 1; gi < 32; gi++) begin : g_busy
         assign busy_next[gi] = (busy_reg[gi] & ~(busy_clr && (wr_addr_reg == 5'(gi))))
                              | (busy_set && (ld_req_rd == 5'(gi)));
      end
   endgenerate
   assign busy_next[0] = 1'b0;

   // Control state: FIFO pointers, scoreboard and the registered write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_wr_ptr_reg <= '0;
         tag_rd_ptr_reg <= '0;
         buf_wr_ptr_reg <= '0;
         buf_rd_ptr_reg <= '0;
         busy_reg       <= '0;
         wr_en_reg      <= 1'b0;
         wr_addr_reg    <= 5'd0;
         wr_data_reg    <= '0;
         wr_from_ld_reg <= 1'b0;
      end else begin
         if (req_fire)  tag_wr_ptr_reg <= tag_wr_ptr_reg + PTR_ONE;
         if (rsp_fire)  tag_rd_ptr_reg <= tag_rd_ptr_reg + PTR_ONE;
         if (buf_push)  buf_wr_ptr_reg <= buf_wr_ptr_reg + PTR_ONE;
         if (drain_pop) buf_rd_ptr_reg <= buf_rd_ptr_reg + PTR_ONE;
         busy_reg       <= busy_next;
         wr_en_reg      <= wr_en_next;
         wr_addr_reg    <= wr_addr_next;
         wr_data_reg    <= wr_data_next;
         wr_from_ld_reg <= wr_from_ld_next;
      end
   end

   // Storage arrays need no reset; pointers alone define valid contents.
   always_ff @(posedge clk) begin
      if (req_fire) tag_mem[tag_wr_ptr_reg[AW-1:0]] <= ld_req_rd;
      if (buf_push) begin
         buf_rd_mem[buf_wr_ptr_reg[AW-1:0]]   <= tag_head;
         buf_data_mem[buf_wr_ptr_reg[AW-1:0]] <= ld_rsp_data;
      end
   end

   assign wr_en   = wr_en_reg;
   assign wr_addr = wr_addr_reg;
   assign wr_data = wr_data_reg;
   assign busy    = busy_reg;

`ifndef SYNTHESIS
   // Load data with no outstanding tag has no destination and is refused.
   a_rsp_without_tag: assert property (@(posedge clk) disable iff (!rst_n)
                                       !(ld_rsp_valid && tag_empty));
`endif

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Testbench for regfile_writeback_unit: ALU vector table, a reference model of
// the write port / scoreboard, and hand sequences for the multi-cycle cases.
module tb_regfile_writeback_unit;
   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
`ifdef WB_LOAD_BYPASS_EN
   localparam int LD_LAT = 1;
`else
   localparam int LD_LAT = 2;
`endif

   typedef struct packed {
      logic [4:0]      addr;
      logic [XLEN-1:0] data;
   } wr_t;

   typedef struct {
      logic            av;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
      logic            exp_ready;
      logic            exp_wr;
   } alu_vec_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            alu_valid = 1'b0;
   logic [4:0]      alu_rd = 5'd0;
   logic [XLEN-1:0] alu_data = '0;
   logic            alu_ready;
   logic            ld_req_valid = 1'b0;
   logic [4:0]      ld_req_rd = 5'd0;
   logic            ld_req_ready;
   logic            ld_rsp_valid = 1'b0;
   logic [XLEN-1:0] ld_rsp_data = '0;
   logic            ld_rsp_ready;
   logic            wr_en;
   logic [4:0]      wr_addr;
   logic [XLEN-1:0] wr_data;
   logic [31:0]     busy;

   int checks = 0;
   int errors = 0;

   wr_t         exp_q [$];
   // Reference model state.
   logic [4:0]  m_tag [$];
   wr_t         m_buf [$];
   logic [31:0] m_busy = '0;
   logic        m_prev_ld = 1'b0;
   logic [4:0]  m_prev_addr = 5'd0;
   wr_t         mon_w;

   alu_vec_t alu_vec [6];

   regfile_writeback_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .ld_req_valid(ld_req_valid), .ld_req_rd(ld_req_rd), .ld_req_ready(ld_req_ready),
      .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data), .ld_rsp_ready(ld_rsp_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every write on the port must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_unexpected: got write x%0d=0x%08h, expected no write", wr_addr, wr_data);
         end else begin
            mon_w = exp_q.pop_front();
            $display("write x%0d = 0x%08h", wr_addr, wr_data);
            check("wr_port", 64'({wr_addr, wr_data}), 64'(mon_w));
         end
      end
   end

   // One clock cycle: drive inputs, check readies against the model, advance
   // the model across the edge, then check wr_en and busy after the edge.
   task automatic cyc(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] adata,
                      input logic qv, input logic [4:0] qrd,
                      input logic sv, input logic [XLEN-1:0] sdata);
      logic m_alu_rdy, m_req_rdy, m_rsp_rdy, alu_w, rsp_acc, byp, nen, nld;
      wr_t  hw, rw, nw;
      alu_valid = av; alu_rd = ard; alu_data = adata;
      ld_req_valid = qv; ld_req_rd = qrd;
      ld_rsp_valid = sv; ld_rsp_data = sdata;
      #1;
      m_alu_rdy = !m_busy[ard];
      m_req_rdy = (m_tag.size() < DEPTH) && !m_busy[qrd];
      m_rsp_rdy = (m_tag.size() > 0) && (m_buf.size() < DEPTH);
      check("alu_ready", 64'(alu_ready), 64'(m_alu_rdy));
      check("ld_req_ready", 64'(ld_req_ready), 64'(m_req_rdy));
      check("ld_rsp_ready", 64'(ld_rsp_ready), 64'(m_rsp_rdy));
      alu_w   = av && m_alu_rdy && (ard != 5'd0);
      rsp_acc = sv && m_rsp_rdy;
      nen = 1'b0; nld = 1'b0; byp = 1'b0; nw = '0;
      if (alu_w) begin
         nen = 1'b1;
         nw  = '{ard, adata};
      end else if (m_buf.size() > 0) begin
         hw = m_buf.pop_front();
         if (hw.addr != 5'd0) begin
            nen = 1'b1; nld = 1'b1; nw = hw;
         end
      end
`ifdef WB_LOAD_BYPASS_EN
      else if (rsp_acc) begin
         byp = 1'b1;
         if (m_tag[0] != 5'd0) begin
            nen = 1'b1; nld = 1'b1; nw = '{m_tag[0], sdata};
         end
      end
`endif
      if (rsp_acc) begin
         rw.addr = m_tag.pop_front();
         rw.data = sdata;
         if (!byp) m_buf.push_back(rw);
      end
      if (m_prev_ld) m_busy[m_prev_addr] = 1'b0;
      if (qv && m_req_rdy) begin
         m_tag.push_back(qrd);
         if (qrd != 5'd0) m_busy[qrd] = 1'b1;
      end
      m_prev_ld   = nld;
      m_prev_addr = nw.addr;
      if (nen) exp_q.push_back(nw);
      @(negedge clk);
      check("wr_en", 64'(wr_en), 64'(nen));
      check("busy", 64'(busy), 64'(m_busy));
   endtask

   task automatic idle();
      cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0, '0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      alu_vec[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b1};
      alu_vec[1] = '{1'b1, 5'd0,  32'hCAFEF00D, 1'b1, 1'b0};
      alu_vec[2] = '{1'b0, 5'd6,  32'h11111111, 1'b1, 1'b0};
      alu_vec[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 1'b1};
      alu_vec[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 1'b1};
      alu_vec[5] = '{1'b0, 5'd0,  32'h00000000, 1'b1, 1'b0};

      // Reset: every output low.
      repeat (3) @(negedge clk);
      #1;
      check("rst_wr_en", 64'(wr_en), 64'(0));
      check("rst_wr_addr", 64'(wr_addr), 64'(0));
      check("rst_wr_data", 64'(wr_data), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_alu_ready", 64'(alu_ready), 64'(0));
      check("rst_ld_req_ready", 64'(ld_req_ready), 64'(0));
      check("rst_ld_rsp_ready", 64'(ld_rsp_ready), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // ALU vector table.
      for (int i = 0; i < 6; i++) begin
         alu_valid = alu_vec[i].av; alu_rd = alu_vec[i].rd; alu_data = alu_vec[i].data;
         #1;
         check("tbl_alu_ready", 64'(alu_ready), 64'(alu_vec[i].exp_ready));
         if (alu_vec[i].exp_wr) exp_q.push_back('{alu_vec[i].rd, alu_vec[i].data});
         @(negedge clk);
         check("tbl_wr_en", 64'(wr_en), 64'(alu_vec[i].exp_wr));
      end
      alu_valid = 1'b0;

      // Load round trip to x7.
      cyc(1'b0, 5'd0, '0, 1'b1, 5'd7, 1'b0, '0);
      check("rt_busy7_set", 64'(busy[7]), 64'(1));
      cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b1, 32'h12345678);
      check("rt_wr_en_first", 64'(wr_en), 64'(LD_LAT == 1));
      for (int k = 1; k < LD_LAT; k++) idle();
      check("rt_wr_addr", 64'(wr_addr), 64'(7));
      check("rt_wr_data", 64'(wr_data), 64'(32'h12345678));
      check("rt_busy7_during_write", 64'(busy[7]), 64'(1));
      cyc(1'b0, 5'd7, '0, 1'b0, 5'd7, 1'b0, '0);
      check("rt_busy7_clear", 64'(busy[7]), 64'(0));

      // Priority: ALU beats a buffered load to x9.
      cyc(1'b0, 5'd0, '0, 1'b1, 5'd9, 1'b0, '0);
      cyc(1'b1, 5'd2, 32'h22222222, 1'b0, 5'd0, 1'b1, 32'h99999999);
      check("prio_first", 64'({wr_en, wr_addr}), 64'({1'b1, 5'd2}));
      cyc(1'b1, 5'd3, 32'h33333333, 1'b0, 5'd0, 1'b0, '0);
      check("prio_alu_x3", 64'({wr_en, wr_addr}), 64'({1'b1, 5'd3}));
      idle();
      check("prio_load_x9", 64'({wr_en, wr_addr, wr_data}), 64'({1'b1, 5'd9, 32'h99999999}));
      idle();
      check("prio_busy_clear", 64'(busy), 64'(0));

      // Hazards on x4.
      cyc(1'b0, 5'd0, '0, 1'b1, 5'd4, 1'b0, '0);
      for (int k = 0; k < 2; k++) begin
         cyc(1'b1, 5'd4, 32'h44440000, 1'b1, 5'd4, 1'b0, '0);
         check("haz_alu_ready", 64'(alu_ready), 64'(0));
         check("haz_ld_req_ready", 64'(ld_req_ready), 64'(0));
      end
      cyc(1'b0, 5'd4, '0, 1'b0, 5'd4, 1'b1, 32'h44444444);
      for (int k = 1; k < LD_LAT; k++) cyc(1'b0, 5'd4, '0, 1'b0, 5'd4, 1'b0, '0);
      check("haz_load_write", 64'({wr_addr, wr_data}), 64'({5'd4, 32'h44444444}));
      check("haz_alu_ready_in_write", 64'(alu_ready), 64'(0));
      cyc(1'b1, 5'd4, 32'h4444EEEE, 1'b0, 5'd4, 1'b0, '0);
      check("haz_alu_ready_after", 64'(alu_ready), 64'(1));
      check("haz_ld_req_ready_after", 64'(ld_req_ready), 64'(1));
      cyc(1'b1, 5'd4, 32'h4444EEEE, 1'b0, 5'd0, 1'b0, '0);
      check("haz_alu_x4", 64'({wr_en, wr_addr, wr_data}), 64'({1'b1, 5'd4, 32'h4444EEEE}));

      // Full tag FIFO (one load to x0), then buffer full under ALU pressure.
      cyc(1'b0, 5'd0, '0, 1'b1, 5'd10, 1'b0, '0);
      cyc(1'b0, 5'd0, '0, 1'b1, 5'd0,  1'b0, '0);
      cyc(1'b0, 5'd0, '0, 1'b1, 5'd12, 1'b0, '0);
      cyc(1'b0, 5'd0, '0, 1'b1, 5'd13, 1'b0, '0);
      cyc(1'b0, 5'd0, '0, 1'b1, 5'd20, 1'b0, '0);
      check("full_ld_req_ready", 64'(ld_req_ready), 64'(0));
      check("full_busy", 64'(busy), 64'(32'h0000_3400));
      for (int i = 0; i < DEPTH; i++)
         cyc(1'b1, 5'd1, 32'hA0000000 + 32'(i), 1'b0, 5'd0, 1'b1, 32'hB0000000 + 32'(i));
      cyc(1'b1, 5'd1, 32'hA0000004, 1'b1, 5'd14, 1'b0, '0);
      cyc(1'b1, 5'd1, 32'hA0000005, 1'b0, 5'd0, 1'b1, 32'hB0000004);
      check("buf_full_rsp_ready", 64'(ld_rsp_ready), 64'(0));
      for (int g = 0; g < 10 && m_tag.size() > 0; g++)
         cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b1, 32'hB0000004);
      for (int j = 0; j < 3; j++)
         cyc(1'b0, 5'd0, '0, 1'b1, 5'(15 + j), 1'b0, '0);
      for (int j = 0; j < 3; j++)
         cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b1, 32'hB0000005 + 32'(j));
      repeat (8) idle();
      check("wrap_busy_clear", 64'(busy), 64'(0));
      check("wrap_all_written", 64'(exp_q.size()), 64'(0));

      // Reset with three loads pending and an ALU write on the port.
      cyc(1'b0, 5'd0, '0, 1'b1, 5'd20, 1'b0, '0);
      cyc(1'b0, 5'd0, '0, 1'b1, 5'd21, 1'b0, '0);
      cyc(1'b0, 5'd0, '0, 1'b1, 5'd22, 1'b0, '0);
      cyc(1'b1, 5'd5, 32'h55555555, 1'b0, 5'd0, 1'b0, '0);
      #2;
      alu_valid = 1'b0; ld_req_valid = 1'b0; ld_rsp_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_wr_en", 64'(wr_en), 64'(0));
      check("midrst_ld_rsp_ready", 64'(ld_rsp_ready), 64'(0));
      m_tag.delete(); m_buf.delete();
      m_busy = '0; m_prev_ld = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b0, 5'd0, '0, 1'b1, 5'd7, 1'b0, '0);
      cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b1, 32'h0BADF00D);
      for (int k = 1; k < LD_LAT; k++) idle();
      check("postrst_write", 64'({wr_en, wr_addr, wr_data}), 64'({1'b1, 5'd7, 32'h0BADF00D}));
      idle();
      check("postrst_busy_clear", 64'(busy), 64'(0));
      idle();
      check("final_scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
